// File: rtl/pwr_rst_seq.sv
// pwr_rst_seq: power-on/button reset sequencer releasing NUM_RST active-low resets in order (optional PWR_RST_SWREQ_EN adds software reset requests)
module pwr_rst_seq #(
  parameter int HOLD_CYCLES    = 5_000_000,
  parameter int STAGGER_CYCLES = 1024,
  parameter int NUM_RST        = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk_50m,
  input  logic               rst_btn_n,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic [NUM_RST-1:0] rst_n,
  output logic               rst_done
);
  localparam int HW  = $clog2(HOLD_CYCLES + 1);
  localparam int STW = $clog2(STAGGER_CYCLES + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [STW-1:0] STG_LAST  = STW'(STAGGER_CYCLES - 1);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [HW-1:0]          r_hold_cnt;
  logic [STW-1:0]         r_stg_cnt;
  logic [NUM_RST-1:0]     r_rst_n;
  logic                   r_rst_done;
  logic                   w_btn_ok;
  logic                   w_lock_ok;
  logic                   w_sw;
  logic                   w_abort;
  logic                   w_ok;
  logic [NUM_RST-1:0]     w_next_rst;
`ifdef PWR_RST_SWREQ_EN
  assign w_sw = sw_rst_req;
`else
  assign w_sw = sw_rst_req & 1'b0;
`endif
  assign w_btn_ok   = r_btn_sync[SYNC_STAGES-1];
  assign w_lock_ok  = r_lock_sync[SYNC_STAGES-1];
  assign w_abort    = ~w_lock_ok | w_sw;
  assign w_ok       = w_btn_ok & ~w_abort;
  assign w_next_rst = (r_rst_n << 1) | NUM_RST'(1);
  assign rst_n      = r_rst_n;
  assign rst_done   = r_rst_done;
  // Button deassert and PLL lock are brought into clk_50m; button assert stays asynchronous
  always_ff @(posedge clk_50m or negedge rst_btn_n) begin
    if (!rst_btn_n) begin
      r_btn_sync  <= '0;
      r_lock_sync <= '0;
    end else begin
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], 1'b1};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end
  // Sequencer: hold until inputs are stable, then release resets one per stagger period
  always_ff @(posedge clk_50m or negedge rst_btn_n) begin
    if (!rst_btn_n) begin
      r_state    <= HOLD;
      r_hold_cnt <= '0;
      r_stg_cnt  <= '0;
      r_rst_n    <= '0;
      r_rst_done <= 1'b0;
    end else if (r_state != HOLD && w_abort) begin
      r_state    <= HOLD;
      r_hold_cnt <= '0;
      r_stg_cnt  <= '0;
      r_rst_n    <= '0;
      r_rst_done <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          if (!w_ok) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_rst_n    <= NUM_RST'(1);
            r_rst_done <= (NUM_RST == 1);
            r_state    <= (NUM_RST == 1) ? RUN : RELEASE;
            r_stg_cnt  <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (r_stg_cnt == STG_LAST) begin
            r_rst_n   <= w_next_rst;
            r_stg_cnt <= '0;
            if (&w_next_rst) begin
              r_rst_done <= 1'b1;
              r_state    <= RUN;
            end
          end else begin
            r_stg_cnt <= r_stg_cnt + 1'b1;
          end
        end
        RUN: r_state <= RUN;
        default: r_state <= HOLD;
      endcase
    end
  end
endmodule
